// File: rtl/lr35902_oam.sv
// lr35902_oam: 160x8 sprite attribute RAM arbitrating DMA, OAM scan, PPU fetch and CPU access
module lr35902_oam #(
   parameter int ENTRIES = 40
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] dma_adr_i,
   input  logic [7:0] dma_din_i,
   input  logic       dma_write_i,
   input  logic       dma_active_i,
   input  logic [7:0] cpu_adr_i,
   input  logic [7:0] cpu_din_i,
   input  logic       cpu_read_i,
   input  logic       cpu_write_i,
   output logic [7:0] cpu_dout_o,
   input  logic       ppu_lock_i,
   input  logic [7:0] ppu_adr_i,
   input  logic       ppu_read_i,
   output logic [7:0] ppu_dout_o,
   input  logic       scan_start_i,
   output logic       scan_busy_o,
   output logic       scan_valid_o,
   output logic [5:0] scan_index_o,
   output logic [7:0] scan_y_o,
   output logic [7:0] scan_x_o
);
   localparam logic [7:0] DEPTH = 8'(4 * ENTRIES);
   localparam logic [5:0] LAST = 6'(ENTRIES - 1);
   typedef enum logic [1:0] {IDLE, RD_Y, RD_X, DRAIN} state_t;
   typedef enum logic [2:0] {S_NONE, S_Y, S_X, S_PPU, S_CPU} src_t;
   state_t state_q, state_d;
   src_t src_q, src_d;
   logic [5:0] idx_q, idx_d, vidx_q, vidx_d;
   logic [7:0] mem [4*ENTRIES];
   logic [7:0] rdat_q;
   logic [7:0] cpu_hold_q, cpu_hold_d, ppu_hold_q, scan_y_q, scan_x_q;
   logic dma_wr, scan_req, scan_go, ppu_go, cpu_blk, cpu_go, cpu_in, cpu_rd_go, cpu_wr_go;
   logic rd_en, wr_en;
   logic [7:0] rd_adr, wr_adr, wr_dat;
   assign dma_wr    = dma_write_i && (dma_adr_i < DEPTH);
   assign scan_req  = (state_q == RD_Y) || (state_q == RD_X);
   assign scan_go   = scan_req && !dma_wr;
   assign ppu_go    = ppu_read_i && (ppu_adr_i < DEPTH) && !dma_wr && !scan_req;
   assign cpu_blk   = dma_active_i | ppu_lock_i | scan_busy_o;
   assign cpu_go    = !cpu_blk && !dma_wr && !scan_req && !ppu_go;
   assign cpu_in    = cpu_adr_i < DEPTH;
   assign cpu_rd_go = cpu_go && cpu_read_i && cpu_in;
   assign cpu_wr_go = cpu_go && cpu_write_i && cpu_in;
   assign rd_en     = scan_go | ppu_go | cpu_rd_go;
   assign rd_adr    = scan_go ? {idx_q, 1'b0, state_q == RD_X} : ppu_go ? ppu_adr_i : cpu_adr_i;
   assign wr_en     = dma_wr | cpu_wr_go;
   assign wr_adr    = dma_wr ? dma_adr_i : cpu_adr_i;
   assign wr_dat    = dma_wr ? dma_din_i : cpu_din_i;
   // Read data is returned from the shared register for one cycle, then held per requester
   assign cpu_dout_o   = (src_q == S_CPU) ? rdat_q : cpu_hold_q;
   assign ppu_dout_o   = (src_q == S_PPU) ? rdat_q : ppu_hold_q;
   assign scan_valid_o = src_q == S_X;
   assign scan_y_o     = (src_q == S_Y) ? rdat_q : scan_y_q;
   assign scan_x_o     = scan_valid_o ? rdat_q : scan_x_q;
   assign scan_index_o = vidx_q;
   assign scan_busy_o  = state_q != IDLE;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (scan_start_i) begin
            state_d = RD_Y;
            idx_d   = '0;
         end
         RD_Y: if (!dma_wr) state_d = RD_X;
         RD_X: if (!dma_wr) begin
            state_d = (idx_q == LAST) ? DRAIN : RD_Y;
            idx_d   = (idx_q == LAST) ? idx_q : idx_q + 6'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      src_d      = scan_go ? ((state_q == RD_X) ? S_X : S_Y) : ppu_go ? S_PPU : cpu_rd_go ? S_CPU : S_NONE;
      vidx_d     = (scan_go && state_q == RD_X) ? idx_q : vidx_q;
      cpu_hold_d = (cpu_read_i && !cpu_go) ? 8'hFF : (cpu_read_i && !cpu_in) ? 8'h00 : cpu_dout_o;
   end
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_adr] <= wr_dat;
      if (rd_en) rdat_q <= mem[rd_adr];
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         src_q      <= S_NONE;
         idx_q      <= '0;
         vidx_q     <= '0;
         cpu_hold_q <= 8'hFF;
         ppu_hold_q <= 8'hFF;
         scan_y_q   <= '0;
         scan_x_q   <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         idx_q      <= idx_d;
         vidx_q     <= vidx_d;
         cpu_hold_q <= cpu_hold_d;
         ppu_hold_q <= ppu_dout_o;
         scan_y_q   <= scan_y_o;
         scan_x_q   <= scan_x_o;
      end
   end
endmodule

// File: tb/tb_lr35902_oam.sv
// tb_lr35902_oam: directed scoreboard bench for the OAM arbiter and scan sequencer
module tb_lr35902_oam;
   typedef struct {logic [5:0] idx; logic [7:0] y; logic [7:0] x;} ent_t;
   logic clk = 0, reset = 0;
   logic [7:0] dma_adr = 0, dma_din = 0, cpu_adr = 0, cpu_din = 0, ppu_adr = 0;
   logic dma_write = 0, dma_active = 0, cpu_read = 0, cpu_write = 0, ppu_lock = 0, ppu_read = 0, scan_start = 0;
   logic [7:0] cpu_dout, ppu_dout, scan_y, scan_x;
   logic scan_busy, scan_valid;
   logic [5:0] scan_index;
   int total = 0, passed = 0, busy_cnt = 0, valid_cnt = 0;
   logic [15:0] e7;
   logic [7:0] cq[$], pq[$];
   ent_t sq[$];
   lr35902_oam dut (
      .clk_i(clk), .reset_i(reset),
      .dma_adr_i(dma_adr), .dma_din_i(dma_din), .dma_write_i(dma_write), .dma_active_i(dma_active),
      .cpu_adr_i(cpu_adr), .cpu_din_i(cpu_din), .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
      .cpu_dout_o(cpu_dout), .ppu_lock_i(ppu_lock), .ppu_adr_i(ppu_adr), .ppu_read_i(ppu_read),
      .ppu_dout_o(ppu_dout), .scan_start_i(scan_start), .scan_busy_o(scan_busy),
      .scan_valid_o(scan_valid), .scan_index_o(scan_index), .scan_y_o(scan_y), .scan_x_o(scan_x)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_rd(input string tag, input logic [7:0] adr, input logic [7:0] exp);
      cpu_adr = adr;
      cpu_read = 1;
      cq.push_back(exp);
      tick();
      cpu_read = 0;
      chk(tag, cpu_dout, cq.pop_front());
   endtask
   task automatic cpu_wr(input logic [7:0] adr, input logic [7:0] d);
      cpu_adr = adr;
      cpu_din = d;
      cpu_write = 1;
      tick();
      cpu_write = 0;
   endtask
   task automatic fill_sb();
      sq.delete();
      for (int i = 0; i < 40; i++) sq.push_back('{6'(i), 8'(4*i) ^ 8'hC3, 8'(4*i+1) ^ 8'hC3});
      busy_cnt = 0;
      valid_cnt = 0;
      e7 = 16'h0000;
   endtask
   task automatic run_scan(input int stall_at, input int exp_busy);
      fill_sb();
      scan_start = 1;
      tick();
      scan_start = 0;
      for (int c = 0; c < 300 && scan_busy; c++) begin
         scan_start = (c == 30);
         dma_write = (c >= stall_at && c < stall_at + 3);
         dma_adr = 8'd5;
         dma_din = 8'd5 ^ 8'hC3;
         tick();
      end
      scan_start = 0;
      dma_write = 0;
      chk("scan_done", {31'd0, scan_busy}, 0);
      chk("busy_cycles", busy_cnt, exp_busy);
      chk("valid_pulses", valid_cnt, 40);
      chk("sb_left", sq.size(), 0);
      chk("entry7", {16'd0, e7}, 32'h0000DFDE);
   endtask
   always @(negedge clk) begin
      if (scan_busy) busy_cnt++;
      if (scan_valid) begin
         valid_cnt++;
         if (scan_index == 6'd7) e7 = {scan_y, scan_x};
         if (sq.size() == 0) begin
            total++;
            $error("FAIL scan_extra observed_index=%0d expected=none", scan_index);
         end else begin
            ent_t e;
            e = sq.pop_front();
            chk("scan_entry", {10'd0, scan_index, scan_y, scan_x}, {10'd0, e.idx, e.y, e.x});
         end
      end
   end
   initial begin
      reset = 1;
      tick();
      tick();
      reset = 0;
      chk("rst_cpu_dout", cpu_dout, 8'hFF);
      chk("rst_ppu_dout", ppu_dout, 8'hFF);
      chk("rst_busy", {31'd0, scan_busy}, 0);
      chk("rst_valid", {31'd0, scan_valid}, 0);
      chk("rst_scan", {10'd0, scan_index, scan_y, scan_x}, 0);
      cpu_wr(8'h10, 8'h5A);
      cpu_rd("cpu_rd_10", 8'h10, 8'h5A);
      chk("cpu_hold", cpu_dout, 8'h5A);
      cpu_rd("cpu_rd_oor", 8'hA5, 8'h00);
      dma_active = 1;
      cpu_rd("cpu_rd_dmalock", 8'h10, 8'hFF);
      cpu_wr(8'h10, 8'h77);
      dma_active = 0;
      cpu_rd("cpu_rd_after_drop", 8'h10, 8'h5A);
      for (int i = 0; i < 160; i++) begin
         dma_adr = 8'(i);
         dma_din = 8'(i) ^ 8'hC3;
         dma_write = 1;
         tick();
      end
      dma_adr = 8'd200;
      dma_din = 8'h00;
      tick();
      dma_write = 0;
      cpu_rd("cpu_rd_dma", 8'h10, 8'hD3);
      cpu_rd("cpu_rd_9f", 8'h9F, 8'h9F ^ 8'hC3);
      ppu_lock = 1;
      cpu_rd("cpu_rd_ppulock", 8'h10, 8'hFF);
      cpu_wr(8'h10, 8'h77);
      ppu_lock = 0;
      cpu_rd("cpu_rd_after_lock", 8'h10, 8'hD3);
      run_scan(1000, 81);
      run_scan(10, 84);
      ppu_adr = 8'd20;
      ppu_read = 1;
      cpu_adr = 8'h10;
      cpu_read = 1;
      pq.push_back(8'd20 ^ 8'hC3);
      cq.push_back(8'hFF);
      tick();
      ppu_read = 0;
      cpu_read = 0;
      chk("ppu_win", ppu_dout, pq.pop_front());
      chk("cpu_lose", cpu_dout, cq.pop_front());
      ppu_adr = 8'd30;
      ppu_read = 1;
      dma_adr = 8'd40;
      dma_din = 8'd40 ^ 8'hC3;
      dma_write = 1;
      pq.push_back(8'd20 ^ 8'hC3);
      tick();
      ppu_read = 0;
      dma_write = 0;
      chk("ppu_lose_dma", ppu_dout, pq.pop_front());
      cpu_rd("cpu_rd_pre_rst", 8'h10, 8'hD3);
      fill_sb();
      scan_start = 1;
      tick();
      scan_start = 0;
      for (int c = 0; c < 100 && !(scan_valid && scan_index == 6'd20); c++) tick();
      chk("reach_e20", {26'd0, scan_valid, scan_index}, {26'd0, 1'b1, 6'd20});
      reset = 1;
      tick();
      reset = 0;
      chk("mid_rst_busy", {31'd0, scan_busy}, 0);
      chk("mid_rst_valid", {31'd0, scan_valid}, 0);
      chk("mid_rst_cpu", cpu_dout, 8'hFF);
      chk("mid_rst_ppu", ppu_dout, 8'hFF);
      chk("mid_rst_scan", {10'd0, scan_index, scan_y, scan_x}, 0);
      run_scan(1000, 81);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
